multicycle_control_fsm: RTL and testbench

//  Main control FSM for the multi-cycle RISC-V core variant. Sequences fetch/decode/execute/

---
 rtl/multicycle_control_fsm_if.sv | 38 +++
 rtl/multicycle_control_fsm.sv | 187 ++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multi-cycle controller, the IR/datapath and the memory port.
// master = controller side, slave = datapath/memory side.
interface multicycle_control_fsm_if;
  logic [6:0] op_i;
  logic [2:0] funct3_i;
  logic       zero_i;
  logic       mem_ready_i;
  logic       pc_write_o;
  logic       pc_src_o;
  logic       ir_write_o;
  logic [2:0] imm_sel_o;
  logic [1:0] alu_src_a_o;
  logic [1:0] alu_src_b_o;
  logic [1:0] alu_op_o;
  logic       mem_req_o;
  logic       mem_we_o;
  logic       i_or_d_o;
  logic       reg_write_o;
  logic [1:0] wb_sel_o;
  logic       instr_done_o;
  logic       illegal_o;
  logic       bus_err_o;
  logic [3:0] state_o;

  modport master (
    input  op_i, funct3_i, zero_i, mem_ready_i,
    output pc_write_o, pc_src_o, ir_write_o, imm_sel_o, alu_src_a_o, alu_src_b_o,
           alu_op_o, mem_req_o, mem_we_o, i_or_d_o, reg_write_o, wb_sel_o,
           instr_done_o, illegal_o, bus_err_o, state_o
  );

  modport slave (
    output op_i, funct3_i, zero_i, mem_ready_i,
    input  pc_write_o, pc_src_o, ir_write_o, imm_sel_o, alu_src_a_o, alu_src_b_o,
           alu_op_o, mem_req_o, mem_we_o, i_or_d_o, reg_write_o, wb_sel_o,
           instr_done_o, illegal_o, bus_err_o, state_o
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the multi-cycle RISC-V core: sequences fetch/decode/execute/mem/wb over
// a shared ALU and a unified memory port, with a per-access memory timeout.
module multicycle_control_fsm #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  multicycle_control_fsm_if.master  bus
);

  typedef enum logic [3:0] {
    S_INIT = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_EXEC_R = 4'd3, S_EXEC_I = 4'd4,
    S_MEM_ADDR = 4'd5, S_MEM_RD = 4'd6, S_MEM_WR = 4'd7, S_WB_ALU = 4'd8, S_WB_MEM = 4'd9,
    S_BRANCH = 4'd10, S_JAL = 4'd11, S_LUI = 4'd12, S_TRAP = 4'd13
  } state_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_t        r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic          r_illegal, r_bus_err;
  logic          w_wait_st, w_timeout;
  logic [2:0]    w_imm;
  logic          w_unused;

  assign w_unused  = &{1'b0, bus.funct3_i[2:1]};
  assign w_wait_st = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
  // A ready on the final allowed cycle still completes the access.
  assign w_timeout = (MEM_TIMEOUT != 0) && w_wait_st && !bus.mem_ready_i && (r_cnt == LAST);

  always_comb begin
    case (bus.op_i)
      OP_I, OP_LD: w_imm = 3'd0;
      OP_ST:       w_imm = 3'd1;
      OP_LUI:      w_imm = 3'd2;
      OP_BR:       w_imm = 3'd3;
      OP_JAL:      w_imm = 3'd4;
      default:     w_imm = 3'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_INIT;
      r_cnt     <= '0;
      r_illegal <= 1'b0;
      r_bus_err <= 1'b0;
    end else begin
      r_state   <= w_next;
      // Any state change clears the counter, so every wait state is entered with zero.
      if (w_next != r_state)
        r_cnt <= '0;
      else if (w_wait_st && (MEM_TIMEOUT != 0))
        r_cnt <= r_cnt + CW'(1);
      r_illegal <= r_illegal | ((r_state == S_DECODE) && (w_next == S_TRAP));
      r_bus_err <= r_bus_err | w_timeout;
    end
  end

  always_comb begin
    w_next           = r_state;
    bus.pc_write_o   = 1'b0;
    bus.pc_src_o     = 1'b0;
    bus.ir_write_o   = 1'b0;
    bus.imm_sel_o    = 3'd0;
    bus.alu_src_a_o  = 2'd0;
    bus.alu_src_b_o  = 2'd0;
    bus.alu_op_o     = 2'd0;
    bus.mem_req_o    = 1'b0;
    bus.mem_we_o     = 1'b0;
    bus.i_or_d_o     = 1'b0;
    bus.reg_write_o  = 1'b0;
    bus.wb_sel_o     = 2'd0;
    bus.instr_done_o = 1'b0;
    case (r_state)
      S_INIT: w_next = S_FETCH;
      S_FETCH: begin
        bus.mem_req_o   = 1'b1;
        bus.alu_src_b_o = 2'd1;
        if (bus.mem_ready_i) begin
          bus.ir_write_o = 1'b1;
          bus.pc_write_o = 1'b1;
          w_next         = S_DECODE;
        end else if (w_timeout) begin
          w_next = S_TRAP;
        end
      end
      S_DECODE: begin
        bus.alu_src_a_o = 2'd1;
        bus.alu_src_b_o = 2'd2;
        case (bus.op_i)
          OP_R:         w_next = S_EXEC_R;
          OP_I:         w_next = S_EXEC_I;
          OP_LD, OP_ST: w_next = S_MEM_ADDR;
          OP_BR:        w_next = S_BRANCH;
          OP_JAL:       w_next = S_JAL;
          OP_LUI:       w_next = S_LUI;
          default:      w_next = S_TRAP;
        endcase
      end
      S_EXEC_R: begin
        bus.alu_src_a_o = 2'd2;
        bus.alu_op_o    = 2'd2;
        w_next          = S_WB_ALU;
      end
      S_EXEC_I: begin
        bus.alu_src_a_o = 2'd2;
        bus.alu_src_b_o = 2'd2;
        bus.alu_op_o    = 2'd2;
        w_next          = S_WB_ALU;
      end
      S_MEM_ADDR: begin
        bus.alu_src_a_o = 2'd2;
        bus.alu_src_b_o = 2'd2;
        w_next          = (bus.op_i == OP_LD) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        bus.mem_req_o = 1'b1;
        bus.i_or_d_o  = 1'b1;
        if (bus.mem_ready_i)  w_next = S_WB_MEM;
        else if (w_timeout)   w_next = S_TRAP;
      end
      S_MEM_WR: begin
        bus.mem_req_o = 1'b1;
        bus.mem_we_o  = 1'b1;
        bus.i_or_d_o  = 1'b1;
        if (bus.mem_ready_i) begin
          bus.instr_done_o = 1'b1;
          w_next           = S_FETCH;
        end else if (w_timeout) begin
          w_next = S_TRAP;
        end
      end
      S_WB_ALU: begin
        bus.reg_write_o  = 1'b1;
        bus.instr_done_o = 1'b1;
        w_next           = S_FETCH;
      end
      S_WB_MEM: begin
        bus.reg_write_o  = 1'b1;
        bus.wb_sel_o     = 2'd1;
        bus.instr_done_o = 1'b1;
        w_next           = S_FETCH;
      end
      S_BRANCH: begin
        bus.alu_src_a_o  = 2'd2;
        bus.alu_op_o     = 2'd1;
        bus.pc_write_o   = bus.zero_i ^ bus.funct3_i[0];
        bus.pc_src_o     = 1'b1;
        bus.instr_done_o = 1'b1;
        w_next           = S_FETCH;
      end
      S_JAL: begin
        bus.reg_write_o  = 1'b1;
        bus.wb_sel_o     = 2'd2;
        bus.pc_write_o   = 1'b1;
        bus.pc_src_o     = 1'b1;
        bus.instr_done_o = 1'b1;
        w_next           = S_FETCH;
      end
      S_LUI: begin
        bus.reg_write_o  = 1'b1;
        bus.wb_sel_o     = 2'd3;
        bus.instr_done_o = 1'b1;
        w_next           = S_FETCH;
      end
      S_TRAP: w_next = S_TRAP;
      default: w_next = S_INIT;
    endcase
    if (!(r_state inside {S_INIT, S_FETCH, S_TRAP}))
      bus.imm_sel_o = w_imm;
  end

  assign bus.state_o   = r_state;
  assign bus.illegal_o = r_illegal;
  assign bus.bus_err_o = r_bus_err;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: directed vector table, trap/reset sequences, then random
// instruction streams checked against an instruction-path reference model.
module tb_multicycle_control_fsm;
  localparam int TO = 4;
  localparam logic [6:0] R = 7'b0110011, OPI = 7'b0010011, LD = 7'b0000011, ST = 7'b0100011;
  localparam logic [6:0] BR = 7'b1100011, JAL = 7'b1101111, LUI = 7'b0110111, BAD = 7'b1111111;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multicycle_control_fsm_if bus();
  multicycle_control_fsm #(.MEM_TIMEOUT(TO)) dut (.clk(clk), .reset(rst_n), .bus(bus));

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic pcw, pcs, irw; logic [2:0] imm; logic [1:0] a, b, aop;
    logic req, we, iord, rw; logic [1:0] wb; logic done, ill, berr; logic [3:0] st;
  } out_t;

  typedef struct packed {
    logic [3:0] st; logic pcw, pcs, irw, rw, done, req, we; logic [2:0] imm;
    logic [1:0] wb; logic ill, berr;
  } sub_t;

  typedef struct {
    logic rst; logic [6:0] op; logic [2:0] f3; logic z, rdy; sub_t e;
  } vec_t;

  function automatic out_t sample();
    out_t o;
    o.pcw = bus.pc_write_o;   o.pcs = bus.pc_src_o;     o.irw = bus.ir_write_o;
    o.imm = bus.imm_sel_o;    o.a = bus.alu_src_a_o;    o.b = bus.alu_src_b_o;
    o.aop = bus.alu_op_o;     o.req = bus.mem_req_o;    o.we = bus.mem_we_o;
    o.iord = bus.i_or_d_o;    o.rw = bus.reg_write_o;   o.wb = bus.wb_sel_o;
    o.done = bus.instr_done_o; o.ill = bus.illegal_o;   o.berr = bus.bus_err_o;
    o.st = bus.state_o;
    return o;
  endfunction

  function automatic sub_t to_sub(out_t o);
    sub_t s;
    s.st = o.st; s.pcw = o.pcw; s.pcs = o.pcs; s.irw = o.irw; s.rw = o.rw; s.done = o.done;
    s.req = o.req; s.we = o.we; s.imm = o.imm; s.wb = o.wb; s.ill = o.ill; s.berr = o.berr;
    return s;
  endfunction

  function automatic vec_t v(logic rst, logic [6:0] op, logic [2:0] f3, logic z, logic rdy,
                             logic [3:0] st, logic pcw, logic pcs, logic irw, logic rw,
                             logic done, logic req, logic we, logic [2:0] imm, logic [1:0] wb,
                             logic ill, logic berr);
    vec_t r;
    r.rst = rst; r.op = op; r.f3 = f3; r.z = z; r.rdy = rdy;
    r.e = '{st, pcw, pcs, irw, rw, done, req, we, imm, wb, ill, berr};
    return r;
  endfunction

  task automatic chk(string name, out_t act, out_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(logic [6:0] op, logic [2:0] f3, logic z, logic rdy);
    bus.op_i = op; bus.funct3_i = f3; bus.zero_i = z; bus.mem_ready_i = rdy;
  endtask

  // ---------------- reference model: instruction path + per-state output rules
  int     m_st, m_cnt;
  bit     m_ill, m_berr;
  int     rest[$];

  function automatic logic [2:0] imm_of(logic [6:0] op);
    case (op)
      OPI, LD: return 3'd0;
      ST:      return 3'd1;
      LUI:     return 3'd2;
      BR:      return 3'd3;
      JAL:     return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  function automatic out_t model_out(int s, logic [6:0] op, logic [2:0] f3, logic z, logic rdy,
                                     bit ill, bit berr);
    out_t o = '0;
    o.st = 4'(s); o.ill = ill; o.berr = berr;
    if (!(s inside {0, 1, 13})) o.imm = imm_of(op);
    case (s)
      1:  begin o.req = 1; o.b = 1; o.irw = rdy; o.pcw = rdy; end
      2:  begin o.a = 1; o.b = 2; end
      3:  begin o.a = 2; o.aop = 2; end
      4:  begin o.a = 2; o.b = 2; o.aop = 2; end
      5:  begin o.a = 2; o.b = 2; end
      6:  begin o.req = 1; o.iord = 1; end
      7:  begin o.req = 1; o.we = 1; o.iord = 1; o.done = rdy; end
      8:  begin o.rw = 1; o.done = 1; end
      9:  begin o.rw = 1; o.wb = 1; o.done = 1; end
      10: begin o.a = 2; o.aop = 1; o.pcw = z ^ f3[0]; o.pcs = 1; o.done = 1; end
      11: begin o.rw = 1; o.wb = 2; o.pcw = 1; o.pcs = 1; o.done = 1; end
      12: begin o.rw = 1; o.wb = 3; o.done = 1; end
      default: ;
    endcase
    return o;
  endfunction

  task automatic load_route(logic [6:0] op);
    case (op)
      R:       rest = '{3, 8};
      OPI:     rest = '{4, 8};
      LD:      rest = '{5, 6, 9};
      ST:      rest = '{5, 7};
      BR:      rest = '{10};
      JAL:     rest = '{11};
      LUI:     rest = '{12};
      default: rest = '{13};
    endcase
  endtask

  task automatic advance();
    if (rest.size() == 0) m_st = 1;
    else begin
      m_st = rest.pop_front();
      if (m_st == 13) m_ill = 1;
    end
    m_cnt = 0;
  endtask

  task automatic model_step(logic [6:0] op, logic rdy);
    if (m_st == 0) begin m_st = 1; m_cnt = 0; end
    else if (m_st == 13) ;
    else if (m_st inside {1, 6, 7}) begin
      if (rdy) begin
        if (m_st == 1) begin load_route(op); m_st = 2; m_cnt = 0; end
        else advance();
      end else if (m_cnt == TO - 1) begin m_st = 13; m_berr = 1; end
      else m_cnt++;
    end else advance();
  endtask

  vec_t tbl[$];
  logic [6:0] ops[7] = '{R, OPI, LD, ST, BR, JAL, LUI};

  initial begin
    drive(R, 0, 0, 0);
    // rst op f3 z rdy | st pcw pcs irw rw done req we imm wb ill berr
    tbl.push_back(v(0, R,  0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, R,  0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, R,  0, 0, 1,  1, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, R,  0, 0, 0,  2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, R,  0, 0, 0,  3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, R,  0, 0, 0,  8, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(v(1, LD, 0, 0, 0,  1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, LD, 0, 0, 1,  1, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, LD, 0, 0, 0,  2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, LD, 0, 0, 0,  5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(v(1, LD, 0, 0, 0,  6, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, LD, 0, 0, 1,  6, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, LD, 0, 0, 0,  9, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0));
    tbl.push_back(v(1, BR, 0, 1, 1,  1, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, BR, 0, 1, 0,  2, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0));
    tbl.push_back(v(1, BR, 0, 1, 0, 10, 1, 1, 0, 0, 1, 0, 0, 3, 0, 0, 0));
    tbl.push_back(v(1, BR, 1, 1, 1,  1, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, BR, 1, 1, 0,  2, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0));
    tbl.push_back(v(1, BR, 1, 1, 0, 10, 0, 1, 0, 0, 1, 0, 0, 3, 0, 0, 0));
    tbl.push_back(v(1, JAL, 0, 0, 1, 1, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, JAL, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 4, 0, 0, 0));
    tbl.push_back(v(1, JAL, 0, 0, 0, 11, 1, 1, 0, 1, 1, 0, 0, 4, 2, 0, 0));
    tbl.push_back(v(1, LUI, 0, 0, 1, 1, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, LUI, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0));
    tbl.push_back(v(1, LUI, 0, 0, 0, 12, 0, 0, 0, 1, 1, 0, 0, 2, 3, 0, 0));
    tbl.push_back(v(1, ST, 0, 0, 1,  1, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, ST, 0, 0, 0,  2, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(v(1, ST, 0, 0, 0,  5, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(v(1, ST, 0, 0, 0, 7, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0));
    tbl.push_back(v(1, ST, 0, 0, 1, 13, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(v(0, BAD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, BAD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, BAD, 0, 0, 1, 1, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, BAD, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, BAD, 0, 0, 0, 13, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst_n = tbl[i].rst;
      drive(tbl[i].op, tbl[i].f3, tbl[i].z, tbl[i].rdy);
      #1;
      checks++;
      if (to_sub(sample()) !== tbl[i].e) begin
        failures++;
        $display("FAIL vec[%0d]: got %h expected %h", i, to_sub(sample()), tbl[i].e);
      end
    end

    // illegal trap must hold with every enable low regardless of inputs
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      drive(BAD, 3'($urandom), 1'($urandom), 1'($urandom));
      #1 chk($sformatf("trap_hold[%0d]", i), sample(),
             model_out(13, BAD, bus.funct3_i, bus.zero_i, bus.mem_ready_i, 1, 0));
    end
    #2 rst_n = 0;
    #1 chk("rst_from_trap", sample(), model_out(0, BAD, 0, 0, 0, 0, 0));

    // reset between clock edges during a pending store drops the write at once
    @(negedge clk); rst_n = 1; drive(ST, 0, 0, 1);
    @(negedge clk);
    @(negedge clk); bus.mem_ready_i = 0;
    @(negedge clk);
    @(negedge clk);
    #1 chk("mid_wr_pending", sample(), model_out(7, ST, 0, 0, 0, 0, 0));
    #1 rst_n = 0;
    #1 chk("rst_mid_wr", sample(), model_out(0, ST, 0, 0, 0, 0, 0));

    // random instruction streams against the path model
    for (int ep = 0; ep < 40; ep++) begin
      int trap_cyc;
      @(negedge clk);
      rst_n = 0;
      #1 chk($sformatf("rand_rst ep%0d", ep), sample(), model_out(0, bus.op_i, 0, 0, 0, 0, 0));
      m_st = 0; m_cnt = 0; m_ill = 0; m_berr = 0; rest.delete();
      trap_cyc = 0;
      for (int cyc = 0; cyc < 150 && trap_cyc < 5; cyc++) begin
        logic [6:0] op;
        @(negedge clk);
        rst_n = 1;
        op = bus.op_i;
        if (m_st == 1) begin
          int r = int'($urandom_range(0, 19));
          op = (r == 0) ? 7'($urandom) : ops[$urandom_range(0, 6)];
        end
        drive(op, 3'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0));
        #1 chk($sformatf("rand ep%0d cyc%0d", ep, cyc), sample(),
               model_out(m_st, bus.op_i, bus.funct3_i, bus.zero_i, bus.mem_ready_i,
                         m_ill, m_berr));
        model_step(bus.op_i, bus.mem_ready_i);
        if (m_st == 13) trap_cyc++;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
